// File: rtl/mips_wb_pkg.sv
// Shared definitions for the MIPS writeback path: load sizes, the JAL link
// register and the writeback mux select encodings.
package mips_wb_pkg;

    localparam int unsigned DW = 32;

    // Load access sizes carried down the pipe with each load.
    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    // Register written by JAL with the return address.
    localparam logic [4:0] RA_REG = 5'd31;

    // Writeback mux selects. Bit 0 drives mux select 0 and bit 1 drives mux
    // select 1. 2'b11 has no meaning and is never produced.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    // Everything the MEM/WB register holds for one instruction.
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] pc_plus4;
        wb_sel_e       sel;
        logic [4:0]    rd;
        logic          reg_write;
        logic          valid;
    } wb_regs_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Little-endian alignment and sign/zero extension of sub-word loads.
module mem_wb_stage_load_align
    import mips_wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half, then extend according to size.
    always_comb begin
        byte_sel = rdata[7:0];
        unique case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        // A misaligned half simply uses the half containing it; there is no trap.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        // NOTE: every path assigns result, and the default covers the
        // reserved size, so this block cannot infer a latch.
        case (size)
            LS_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            LS_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the memory-stage results, aligns loads,
// drives the writeback mux operands/selects and counts retired instructions.
module mem_wb_stage
    import mips_wb_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter logic [4:0]  RA_REG = mips_wb_pkg::RA_REG
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          m_valid,
    input  logic [DW-1:0] m_alu_result,
    input  logic [DW-1:0] m_mem_rdata,
    input  logic [DW-1:0] m_pc_plus4,
    input  logic [4:0]    m_rd,
    input  logic          m_reg_write,
    input  logic          m_mem_to_reg,
    input  logic          m_jal,
    input  logic [1:0]    m_load_size,
    input  logic          m_load_unsigned,
    output logic [DW-1:0] wb_a,
    output logic [DW-1:0] wb_b,
    output logic [DW-1:0] wb_pc_plus4,
    output logic [1:0]    wb_sel_0,
    output logic [1:0]    wb_sel_1,
    output logic [4:0]    wb_rd,
    output logic          wb_reg_write,
    output logic          wb_valid,
    output logic [31:0]   retired_count
);

    wb_regs_t    regs_d, regs_q;
    logic [31:0] retired_d, retired_q;
    logic [31:0] load_data;
    logic        retire;

    mem_wb_stage_load_align u_load_align (
        .rdata       (m_mem_rdata),
        .offset      (m_alu_result[1:0]),
        .size        (m_load_size),
        .is_unsigned (m_load_unsigned),
        .result      (load_data)
    );

    // Next-state selection: flush beats stall, stall beats load, and an
    // invalid MEM slot loads as a bubble exactly like a flush.
    always_comb begin
        regs_d = regs_q;
        if (flush || !stall) begin
            if (flush || !m_valid) begin
                regs_d = '0;
            end else begin
                regs_d.a         = m_alu_result;
                regs_d.b         = load_data;
                regs_d.pc_plus4  = m_pc_plus4;
                regs_d.sel       = m_jal        ? WB_PC4 :
                                   m_mem_to_reg ? WB_MEM : WB_ALU;
                regs_d.rd        = m_jal ? RA_REG : m_rd;
                regs_d.reg_write = m_jal | (m_reg_write & (m_rd != 5'd0));
                regs_d.valid     = 1'b1;
            end
        end
    end

    // The WB instruction retires whenever it leaves the stage; a flush
    // overrides a stall, so the occupant still leaves on a flush edge.
    always_comb begin
        retire    = regs_q.valid & (flush | ~stall);
        retired_d = retired_q + {31'd0, retire};
    end

    // Stage registers and retirement counter.
    // NOTE: non-blocking assignments keep every flop sampling the pre-edge
    // value regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '0;
            retired_q <= '0;
        end else begin
            regs_q    <= regs_d;
            retired_q <= retired_d;
        end
    end

    assign wb_a          = regs_q.a;
    assign wb_b          = regs_q.b;
    assign wb_pc_plus4   = regs_q.pc_plus4;
    assign wb_sel_0      = {1'b0, regs_q.sel[0]};
    assign wb_sel_1      = {1'b0, regs_q.sel[1]};
    assign wb_rd         = regs_q.rd;
    assign wb_reg_write  = regs_q.reg_write;
    assign wb_valid      = regs_q.valid;
    assign retired_count = retired_q;

endmodule
